// File: rtl/ula_ctrl.sv
// Command/response front-end for the combinational 8-bit ULA: registers operands, waits SETTLE_CYCLES, captures the result.
// Optional feature macro: ULA_CTRL_ACCUM_EN (adds i_cmd_acc and an 8-bit operand-A accumulator).
module ula_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [7:0]  i_cmd_a,
    input  logic [7:0]  i_cmd_b,
    input  logic [3:0]  i_cmd_op,
`ifdef ULA_CTRL_ACCUM_EN
    input  logic        i_cmd_acc,
`endif
    output logic [7:0]  o_ula_a,
    output logic [7:0]  o_ula_b,
    output logic [3:0]  o_ula_op,
    input  logic [15:0] i_ula_result,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [15:0] o_rsp_result,
    output logic        o_rsp_zero,
    output logic        o_rsp_err,
    output logic        o_busy
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // DRIVE | ULA inputs held, settle counter running
    // RESP  | captured response presented, waiting for rsp_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] OP_DIV      = 4'b1001;
    localparam logic [3:0] OP_LAST     = 4'b1100;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [7:0]  r_ula_a;
    logic [7:0]  r_ula_b;
    logic [3:0]  r_ula_op;
    logic [15:0] r_rsp_result;
    logic        r_rsp_zero;
    logic        r_rsp_err;

    logic        w_accept;
    logic        w_capture;
    logic        w_rsp_hs;
    logic        w_cap_err;
    logic [15:0] w_cap_result;
    logic [7:0]  w_operand_a;

`ifdef ULA_CTRL_ACCUM_EN
    logic [7:0]  r_acc;

    assign w_operand_a = i_cmd_acc ? r_acc : i_cmd_a;

    // Error responses carry no usable data, so only clean results feed back.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= 8'h00;
        end else if (w_rsp_hs && !r_rsp_err) begin
            r_acc <= r_rsp_result[7:0];
        end
    end
`else
    assign w_operand_a = i_cmd_a;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_rsp_hs    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // DIV by zero may leave the ULA output undefined, so the result is forced rather than passed through.
    assign w_cap_err    = (r_ula_op > OP_LAST) || ((r_ula_op == OP_DIV) && (r_ula_b == 8'h00));
    assign w_cap_result = w_cap_err ? 16'h0000 : i_ula_result;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_ula_a      <= 8'h00;
            r_ula_b      <= 8'h00;
            r_ula_op     <= 4'h0;
            r_rsp_result <= 16'h0000;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ula_a  <= w_operand_a;
                r_ula_b  <= i_cmd_b;
                r_ula_op <= i_cmd_op;
                r_cnt    <= SETTLE_INIT;
            end else if ((r_state == DRIVE) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_rsp_result <= w_cap_result;
                r_rsp_zero   <= (w_cap_result == 16'h0000);
                r_rsp_err    <= w_cap_err;
            end
        end
    end

    assign o_cmd_ready  = (r_state == IDLE) && !i_rst;
    assign o_rsp_valid  = (r_state == RESP);
    assign o_busy       = (r_state != IDLE);
    assign o_ula_a      = r_ula_a;
    assign o_ula_b      = r_ula_b;
    assign o_ula_op     = r_ula_op;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_zero   = r_rsp_zero;
    assign o_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_ula_ctrl.sv
// Bench for ula_ctrl: three instances (settle 1, 4, 3) fed by a behavioural ULA; expected responses go through a scoreboard queue.
module tb_ula_ctrl;

    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b0111;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_EQ  = 4'b1100;

    typedef struct {
        logic [15:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst        [3];
    logic        cmd_valid  [3];
    logic        cmd_ready  [3];
    logic [7:0]  cmd_a      [3];
    logic [7:0]  cmd_b      [3];
    logic [3:0]  cmd_op     [3];
    logic        cmd_acc    [3];
    logic [7:0]  ula_a      [3];
    logic [7:0]  ula_b      [3];
    logic [3:0]  ula_op     [3];
    logic        rsp_valid  [3];
    logic        rsp_ready  [3];
    logic [15:0] rsp_result [3];
    logic        rsp_zero   [3];
    logic        rsp_err    [3];
    logic        busy       [3];

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // Behavioural ULA; illegal opcodes return junk so the controller's zeroing is visible.
    function automatic logic [15:0] ula_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case (op)
            4'b0000: return {8'h00, a & b};
            4'b0001: return {8'h00, a | b};
            4'b0010: return {8'h00, a ^ b};
            OP_ADD:  return 16'(a) + 16'(b);
            OP_SUB:  return 16'(a) - 16'(b);
            OP_MUL:  return 16'(a) * 16'(b);
            OP_DIV:  return (b == 8'h00) ? 16'hxxxx : {8'h00, a / b};
            OP_EQ:   return {15'h0000, a == b};
            default: return 16'hDEAD;
        endcase
    endfunction

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 4 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ula_ctrl #(.SETTLE_CYCLES((g == 0) ? 1 : ((g == 1) ? 4 : 3))) u_dut (
            .i_clk        (clk),
            .i_rst        (rst[g]),
            .i_cmd_valid  (cmd_valid[g]),
            .o_cmd_ready  (cmd_ready[g]),
            .i_cmd_a      (cmd_a[g]),
            .i_cmd_b      (cmd_b[g]),
            .i_cmd_op     (cmd_op[g]),
`ifdef ULA_CTRL_ACCUM_EN
            .i_cmd_acc    (cmd_acc[g]),
`endif
            .o_ula_a      (ula_a[g]),
            .o_ula_b      (ula_b[g]),
            .o_ula_op     (ula_op[g]),
            .i_ula_result (ula_model(ula_a[g], ula_b[g], ula_op[g])),
            .o_rsp_valid  (rsp_valid[g]),
            .i_rsp_ready  (rsp_ready[g]),
            .o_rsp_result (rsp_result[g]),
            .o_rsp_zero   (rsp_zero[g]),
            .o_rsp_err    (rsp_err[g]),
            .o_busy       (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command on instance d. 'a' is the operand the ULA must see; with acc set, cmd_a carries its
    // complement so a controller that ignores the accumulator is caught. hold = cycles of rsp_ready low.
    task automatic send(input int d, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic acc, input logic [15:0] eres, input logic eerr, input int hold,
                        input string tag);
        exp_t        e;
        exp_t        got;
        int          lat;
        logic [15:0] snap_res;
        logic        snap_zero;
        logic        snap_err;
        e.res  = eres;
        e.err  = eerr;
        e.zero = (eres == 16'h0000);
        sb.push_back(e);
        @(negedge clk);
        check({tag, "_cmd_ready"}, 32'(cmd_ready[d]), 32'd1);
        cmd_valid[d] = 1'b1;
        cmd_a[d]     = acc ? ~a : a;
        cmd_b[d]     = b;
        cmd_op[d]    = op;
        cmd_acc[d]   = acc;
        rsp_ready[d] = (hold == 0);
        @(posedge clk);
        #1;
        cmd_valid[d] = 1'b0;
        check({tag, "_ula_a"}, 32'(ula_a[d]), 32'(a));
        check({tag, "_ula_op"}, 32'(ula_op[d]), 32'(op));
        check({tag, "_busy"}, 32'(busy[d]), 32'd1);
        lat = 0;
        while (!rsp_valid[d] && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check({tag, "_latency"}, 32'(lat), 32'(settle_of(d)));
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check({tag, "_result"}, 32'(rsp_result[d]), 32'(got.res));
            check({tag, "_zero"}, 32'(rsp_zero[d]), 32'(got.zero));
            check({tag, "_err"}, 32'(rsp_err[d]), 32'(got.err));
        end
        if (hold > 0) begin
            snap_res  = rsp_result[d];
            snap_zero = rsp_zero[d];
            snap_err  = rsp_err[d];
            cmd_valid[d] = 1'b1;
            cmd_a[d]     = 8'hEE;
            cmd_b[d]     = 8'h11;
            cmd_op[d]    = OP_SUB;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check({tag, "_hold_valid"}, 32'(rsp_valid[d]), 32'd1);
                check({tag, "_hold_result"}, 32'(rsp_result[d]), 32'(snap_res));
                check({tag, "_hold_flags"}, {30'd0, rsp_zero[d], rsp_err[d]}, {30'd0, snap_zero, snap_err});
                check({tag, "_hold_ula"}, {12'd0, ula_a[d], ula_b[d], ula_op[d]}, {12'd0, a, b, op});
                check({tag, "_hold_cmd_ready"}, 32'(cmd_ready[d]), 32'd0);
            end
            cmd_valid[d] = 1'b0;
            rsp_ready[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "_post_valid"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, "_post_cmd_ready"}, 32'(cmd_ready[d]), 32'd1);
        check({tag, "_post_busy"}, 32'(busy[d]), 32'd0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d]       = 1'b1;
            cmd_valid[d] = 1'b0;
            cmd_a[d]     = 8'h00;
            cmd_b[d]     = 8'h00;
            cmd_op[d]    = 4'h0;
            cmd_acc[d]   = 1'b0;
            rsp_ready[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_valid", 32'(rsp_valid[d]), 32'd0);
            check("rst_busy", 32'(busy[d]), 32'd0);
            check("rst_cmd_ready", 32'(cmd_ready[d]), 32'd0);
            check("rst_ula", {12'd0, ula_a[d], ula_b[d], ula_op[d]}, 32'd0);
            check("rst_rsp", {14'd0, rsp_result[d], rsp_zero[d], rsp_err[d]}, 32'd0);
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        #1;
        check("rst_release_ready", 32'(cmd_ready[0]), 32'd1);

        send(0, 8'd200, 8'd100, OP_ADD, 1'b0, 16'h012C, 1'b0, 0, "add");
        send(0, 8'd3,   8'd5,   OP_SUB, 1'b0, 16'hFFFE, 1'b0, 0, "sub");
        send(0, 8'd9,   8'd9,   OP_EQ,  1'b0, 16'h0001, 1'b0, 0, "eq");
        send(0, 8'd100, 8'd7,   OP_DIV, 1'b0, 16'h000E, 1'b0, 0, "div");
        send(0, 8'd7,   8'd0,   OP_DIV, 1'b0, 16'h0000, 1'b1, 0, "div0");
        send(0, 8'd7,   8'd3,   4'b1110, 1'b0, 16'h0000, 1'b1, 0, "op1110");
        send(0, 8'd7,   8'd3,   4'b1101, 1'b0, 16'h0000, 1'b1, 0, "op1101");
        send(0, 8'h12,  8'h34,  OP_ADD, 1'b0, 16'h0046, 1'b0, 5, "bp");
        send(1, 8'd255, 8'd255, OP_MUL, 1'b0, 16'hFE01, 1'b0, 0, "mul");

        // Reset while instance 2 sits in DRIVE.
        @(negedge clk);
        cmd_valid[2] = 1'b1;
        cmd_a[2]     = 8'hA5;
        cmd_b[2]     = 8'h3C;
        cmd_op[2]    = OP_ADD;
        @(posedge clk);
        #1;
        cmd_valid[2] = 1'b0;
        check("mid_busy", 32'(busy[2]), 32'd1);
        @(negedge clk);
        rst[2] = 1'b1;
        @(posedge clk);
        #1;
        check("mid_ula", {12'd0, ula_a[2], ula_b[2], ula_op[2]}, 32'd0);
        check("mid_rsp", {14'd0, rsp_result[2], rsp_zero[2], rsp_err[2]}, 32'd0);
        check("mid_valid_busy", {30'd0, rsp_valid[2], busy[2]}, 32'd0);
        check("mid_cmd_ready_in_rst", 32'(cmd_ready[2]), 32'd0);
        @(negedge clk);
        rst[2] = 1'b0;
        #1;
        check("mid_cmd_ready_after", 32'(cmd_ready[2]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("mid_no_rsp", 32'(rsp_valid[2]), 32'd0);
        end
        send(2, 8'd3, 8'd5, OP_SUB, 1'b0, 16'hFFFE, 1'b0, 0, "sub_s3");

`ifdef ULA_CTRL_ACCUM_EN
        send(0, 8'd10, 8'd5, OP_ADD, 1'b0, 16'd15, 1'b0, 0, "acc_add");
        send(0, 8'd15, 8'd1, OP_ADD, 1'b1, 16'd16, 1'b0, 0, "acc_use");
        send(0, 8'd16, 8'd0, OP_DIV, 1'b1, 16'h0000, 1'b1, 0, "acc_err");
        send(0, 8'd16, 8'd0, OP_ADD, 1'b1, 16'd16, 1'b0, 0, "acc_kept");
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
